ifid_hazard_queue: RTL and testbench

- Pipeline register between instruction fetch and the regfileread stage.
- Holds the fetched instruction and its PC, and detects load-use hazards against the instruction currently in regfileread.
- Stalls fetch and injects a bubble into the regfileread queue on a load-use hazard.
- Flushes on a taken branch, and counts hazard stalls for performance monitoring.

---
 rtl/ifid_hazard_queue_if.sv | 32 +++
 rtl/ifid_hazard_queue.sv | 136 +++++++++++++
 tb/tb_ifid_hazard_queue.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ifid_hazard_queue_if.sv
// Bus between instruction fetch, the IF/ID pipeline register and the regfileread stage.
// The slave modport is the pipeline register; the master modport is the surrounding pipeline.
interface ifid_hazard_queue_if #(
  parameter int CNT_W = 16
);
  // fetch side
  logic [31:0]      Instr;
  logic [63:0]      PC;
  logic             InValid;
  // regfileread-stage and pipeline-control side
  logic             RfMemRead;
  logic [4:0]       RfRd;
  logic             BrTaken;
  logic             ExtStall;
  // results
  logic [31:0]      InstrO;
  logic [63:0]      PCO;
  logic             ValidO;
  logic             PCStall;
  logic             BubbleO;
  logic [CNT_W-1:0] StallCnt;

  modport master (
    output Instr, PC, InValid, RfMemRead, RfRd, BrTaken, ExtStall,
    input  InstrO, PCO, ValidO, PCStall, BubbleO, StallCnt
  );

  modport slave (
    input  Instr, PC, InValid, RfMemRead, RfRd, BrTaken, ExtStall,
    output InstrO, PCO, ValidO, PCStall, BubbleO, StallCnt
  );
endinterface

// File: rtl/ifid_hazard_queue.sv
// IF/ID pipeline register with load-use hazard detection, branch flush and a
// saturating count of load-use stall cycles.
module ifid_hazard_queue #(
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [31:0] NOP_INSTR    = 32'hD503201F,
  parameter int          CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  ifid_hazard_queue_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  logic [31:0]      instr_q, instr_d;
  logic [63:0]      pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [1:0]       src_match;
  logic             haz;
  logic             pc_stall;
  logic             bubble;

  // Rn lives in [9:5], Rm in [20:16]; both are compared whatever the opcode.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      localparam int LSB = (gi == 0) ? 5 : 16;
      assign src_match[gi] = (instr_q[LSB +: 5] == bus.RfRd);
    end
  endgenerate

  assign haz = valid_q & bus.RfMemRead & (bus.RfRd != 5'd31) & (|src_match);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 3'd0;
      instr_q     <= NOP_INSTR;
      pc_q        <= 64'd0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state and datapath update, priority BrTaken > ExtStall > hazard > advance
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;

    if (bus.BrTaken) begin
      state_d     = ST_FLUSH;
      flush_cnt_d = 3'(FLUSH_CYCLES - 1);
      instr_d     = NOP_INSTR;
      valid_d     = 1'b0;
    end else if (!bus.ExtStall) begin
      unique case (state_q)
        ST_RUN: begin
          if (haz) begin
            state_d = ST_LDSTALL;
            if (stall_cnt_q != '1) begin
              stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
          end else begin
            instr_d = bus.InValid ? bus.Instr : NOP_INSTR;
            pc_d    = bus.PC;
            valid_d = bus.InValid;
          end
        end
        // The load has left regfileread by now, so forwarding covers the
        // dependency and the held instruction simply advances.
        ST_LDSTALL: begin
          state_d = ST_RUN;
          instr_d = bus.InValid ? bus.Instr : NOP_INSTR;
          pc_d    = bus.PC;
          valid_d = bus.InValid;
        end
        ST_FLUSH: begin
          if (flush_cnt_q == 3'd0) begin
            state_d = ST_RUN;
            instr_d = bus.InValid ? bus.Instr : NOP_INSTR;
            pc_d    = bus.PC;
            valid_d = bus.InValid;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
            instr_d     = NOP_INSTR;
            valid_d     = 1'b0;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Control outputs; both forced low while reset is held
  always_comb begin
    pc_stall = 1'b0;
    bubble   = 1'b0;
    if (reset && !bus.BrTaken) begin
      if (bus.ExtStall) begin
        pc_stall = 1'b1;
      end else if (state_q == ST_RUN && haz) begin
        pc_stall = 1'b1;
        bubble   = 1'b1;
      end
    end
  end

  assign bus.InstrO   = instr_q;
  assign bus.PCO      = pc_q;
  assign bus.ValidO   = valid_q;
  assign bus.PCStall  = pc_stall;
  assign bus.BubbleO  = bubble;
  assign bus.StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_ifid_hazard_queue.sv
// Directed bench for ifid_hazard_queue with FLUSH_CYCLES=2 and a 2-bit stall counter.
module tb_ifid_hazard_queue;

  localparam int          FLUSH_CYCLES = 2;
  localparam int          CNT_W        = 2;
  localparam logic [31:0] NOP          = 32'hD503201F;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ifid_hazard_queue_if #(.CNT_W(CNT_W)) bus ();

  ifid_hazard_queue #(
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .NOP_INSTR    (NOP),
    .CNT_W        (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset         = 1'b0;
    bus.Instr     = 32'h0;
    bus.PC        = 64'h0;
    bus.InValid   = 1'b0;
    bus.RfMemRead = 1'b0;
    bus.RfRd      = 5'd0;
    bus.BrTaken   = 1'b0;
    bus.ExtStall  = 1'b1;
    step();
    step();
    #1;
    chk("rst_instr",    64'(bus.InstrO), 64'(NOP));
    chk("rst_pc",       bus.PCO, 64'h0);
    chk("rst_valid",    64'(bus.ValidO), 64'h0);
    chk("rst_pcstall",  64'(bus.PCStall), 64'h0);
    chk("rst_bubble",   64'(bus.BubbleO), 64'h0);
    chk("rst_cnt",      64'(bus.StallCnt), 64'h0);
    $display("reset state checked");

    // Stream one instruction (Rn=1, Rm=2)
    reset       = 1'b1;
    bus.ExtStall = 1'b0;
    bus.Instr   = 32'h8B020020;
    bus.PC      = 64'h100;
    bus.InValid = 1'b1;
    step();
    chk("stream_instr",   64'(bus.InstrO), 64'h8B020020);
    chk("stream_pc",      bus.PCO, 64'h100);
    chk("stream_valid",   64'(bus.ValidO), 64'h1);
    chk("stream_pcstall", 64'(bus.PCStall), 64'h0);
    $display("stream: InstrO=%h PCO=%h", bus.InstrO, bus.PCO);

    // Load-use on Rn=1 (next instr has Rn=31, Rm=3)
    bus.Instr     = 32'hAA0303E4;
    bus.PC        = 64'h104;
    bus.RfMemRead = 1'b1;
    bus.RfRd      = 5'd1;
    #1;
    chk("lu_pcstall", 64'(bus.PCStall), 64'h1);
    chk("lu_bubble",  64'(bus.BubbleO), 64'h1);
    step();
    chk("lu_hold_instr", 64'(bus.InstrO), 64'h8B020020);
    chk("lu_hold_pc",    bus.PCO, 64'h100);
    chk("lu_cnt",        64'(bus.StallCnt), 64'h1);
    chk("ldst_pcstall",  64'(bus.PCStall), 64'h0);
    chk("ldst_bubble",   64'(bus.BubbleO), 64'h0);
    step();
    chk("lu_adv_instr", 64'(bus.InstrO), 64'hAA0303E4);
    chk("lu_adv_pc",    bus.PCO, 64'h104);
    chk("nomatch_pcstall", 64'(bus.PCStall), 64'h0);
    $display("load-use: StallCnt=%0d", bus.StallCnt);

    // XZR destination never stalls even though Rn=31
    bus.RfRd = 5'd31;
    #1;
    chk("xzr_pcstall", 64'(bus.PCStall), 64'h0);
    chk("xzr_bubble",  64'(bus.BubbleO), 64'h0);
    // Matching Rm but not a load
    bus.RfRd      = 5'd3;
    bus.RfMemRead = 1'b0;
    #1;
    chk("noload_pcstall", 64'(bus.PCStall), 64'h0);
    step();
    chk("noload_cnt", 64'(bus.StallCnt), 64'h1);
    $display("xzr/non-load: no stall");

    // Branch taken while hazard is also present
    bus.RfMemRead = 1'b1;
    bus.BrTaken   = 1'b1;
    bus.Instr     = 32'h12345678;
    bus.PC        = 64'h200;
    #1;
    chk("br_pcstall", 64'(bus.PCStall), 64'h0);
    chk("br_bubble",  64'(bus.BubbleO), 64'h0);
    step();
    bus.BrTaken   = 1'b0;
    bus.RfMemRead = 1'b0;
    chk("fl1_instr", 64'(bus.InstrO), 64'(NOP));
    chk("fl1_valid", 64'(bus.ValidO), 64'h0);
    chk("fl1_cnt",   64'(bus.StallCnt), 64'h1);
    step();
    chk("fl2_valid", 64'(bus.ValidO), 64'h0);
    step();
    chk("flx_instr", 64'(bus.InstrO), 64'h12345678);
    chk("flx_valid", 64'(bus.ValidO), 64'h1);
    chk("flx_pc",    bus.PCO, 64'h200);
    chk("flx_cnt",   64'(bus.StallCnt), 64'h1);
    $display("flush: reloaded InstrO=%h", bus.InstrO);

    // ExtStall with hazard on Rm=20 of 12345678
    bus.RfMemRead = 1'b1;
    bus.RfRd      = 5'd20;
    bus.ExtStall  = 1'b1;
    bus.Instr     = 32'hCAFE0000;
    bus.PC        = 64'h300;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ext_pcstall", 64'(bus.PCStall), 64'h1);
      chk("ext_bubble",  64'(bus.BubbleO), 64'h0);
      step();
      chk("ext_instr", 64'(bus.InstrO), 64'h12345678);
      chk("ext_cnt",   64'(bus.StallCnt), 64'h1);
    end
    bus.ExtStall = 1'b0;
    #1;
    chk("extrel_pcstall", 64'(bus.PCStall), 64'h1);
    chk("extrel_bubble",  64'(bus.BubbleO), 64'h1);
    step();
    chk("extrel_instr", 64'(bus.InstrO), 64'h12345678);
    chk("extrel_cnt",   64'(bus.StallCnt), 64'h2);
    bus.RfMemRead = 1'b0;
    step();
    chk("extrel_adv", 64'(bus.InstrO), 64'hCAFE0000);
    $display("ext stall: StallCnt=%0d", bus.StallCnt);

    // Saturation: Rn=19 of 12345678 hazards every other cycle
    bus.Instr     = 32'h12345678;
    bus.PC        = 64'h400;
    bus.RfMemRead = 1'b1;
    bus.RfRd      = 5'd19;
    #1;
    chk("sat_pre_pcstall", 64'(bus.PCStall), 64'h0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("sat_pcstall", 64'(bus.PCStall), 64'h1);
      step();
      chk("sat_cnt", 64'(bus.StallCnt), 64'((i + 3 > 3) ? 3 : i + 3));
      step();
    end
    $display("saturation: StallCnt=%0d", bus.StallCnt);

    // Invalid fetch loads NOP
    bus.RfMemRead = 1'b0;
    bus.InValid   = 1'b0;
    step();
    chk("inv_instr", 64'(bus.InstrO), 64'(NOP));
    chk("inv_valid", 64'(bus.ValidO), 64'h0);

    // Async reset in the middle of a flush
    bus.InValid = 1'b1;
    step();
    bus.BrTaken = 1'b1;
    step();
    bus.BrTaken  = 1'b0;
    bus.ExtStall = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_instr",   64'(bus.InstrO), 64'(NOP));
    chk("arst_pc",      bus.PCO, 64'h0);
    chk("arst_valid",   64'(bus.ValidO), 64'h0);
    chk("arst_cnt",     64'(bus.StallCnt), 64'h0);
    chk("arst_pcstall", 64'(bus.PCStall), 64'h0);
    step();
    reset        = 1'b1;
    bus.ExtStall = 1'b0;
    bus.Instr    = 32'h8B020020;
    bus.PC       = 64'h500;
    step();
    chk("post_rst_instr", 64'(bus.InstrO), 64'h8B020020);
    chk("post_rst_valid", 64'(bus.ValidO), 64'h1);
    chk("post_rst_pc",    bus.PCO, 64'h500);
    $display("async reset: reload InstrO=%h", bus.InstrO);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
